// File: rtl/audio_i2s_tx.sv
`timescale 1ns/1ps
// audio_i2s_tx: stereo sample FIFO feeding a free-running I2S serializer.
// Each 32-bit word {left, right} is sent over one 32-slot frame with the
// standard one-bit I2S delay, so the last bit of a word lands in slot 0 of
// the next frame while the following word is being loaded.
module audio_i2s_tx #(
  parameter int FIFO_DEPTH = 16,
  parameter int BCLK_DIV   = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          enable,
  input  logic [31:0]                   sample_data,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  input  logic                          clear_underflow,
  output logic [15:0]                   underflow_cnt,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_sdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } tx_state_t;

  // Sample storage and bookkeeping
  logic [31:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_next;
  logic          ready_q;

  // Serializer state
  tx_state_t     state;
  logic [DW-1:0] div_cnt;
  logic [4:0]    slot_cnt;
  logic [4:0]    slot_next;
  logic          bclk_q;
  logic          lrclk_q;
  logic          sdata_q;
  logic [31:0]   shift_q;
  logic [15:0]   uf_count;

  // Event decode
  logic          push;
  logic          pop;
  logic          div_term;
  logic          bclk_fall;
  logic          start;
  logic          frame_entry;
  logic          fifo_empty;
  logic          underflow;
  logic [31:0]   pop_word;

  assign push        = sample_valid && ready_q;
  assign fifo_empty  = (level_q == '0);
  assign div_term    = (div_cnt == DW'(BCLK_DIV - 1));
  assign start       = enable && (state == ST_IDLE);
  assign bclk_fall   = enable && (state == ST_RUN) && div_term && bclk_q;
  assign slot_next   = slot_cnt + 5'd1;
  assign frame_entry = start || (bclk_fall && (slot_cnt == 5'd31));
  assign pop         = frame_entry && !fifo_empty;
  assign underflow   = frame_entry && fifo_empty;
  assign pop_word    = pop ? fifo_mem[rd_ptr] : 32'h0;

  // Next occupancy after this cycle's push and pop; a simultaneous pair cancels
  always_comb begin
    level_next = level_q;
    if (push && !pop) begin
      level_next = level_q + LW'(1);
    end else if (!push && pop) begin
      level_next = level_q - LW'(1);
    end
  end

  // Sample memory write port; contents need no reset since pointers define validity
  always_ff @(posedge ACLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= sample_data;
    end
  end

  // FIFO pointers, occupancy and a registered ready so valid never reaches ready combinationally
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level_q <= level_next;
      ready_q <= (level_next != LW'(FIFO_DEPTH));
    end
  end

  // Clock divider, slot sequencing and shift-out; disabling drops everything back to idle at once
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      slot_cnt <= '0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
      shift_q  <= '0;
    end else if (!enable) begin
      state    <= ST_IDLE;
      div_cnt  <= '0;
      slot_cnt <= '0;
      bclk_q   <= 1'b0;
      lrclk_q  <= 1'b0;
      sdata_q  <= 1'b0;
      shift_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_RUN;
          div_cnt  <= '0;
          slot_cnt <= '0;
          bclk_q   <= 1'b0;
          lrclk_q  <= 1'b0;
          sdata_q  <= 1'b0;
          shift_q  <= pop_word;
        end
        ST_RUN: begin
          if (div_term) begin
            div_cnt <= '0;
            bclk_q  <= ~bclk_q;
            if (bclk_q) begin
              slot_cnt <= slot_next;
              lrclk_q  <= slot_next[4];
              sdata_q  <= shift_q[31];
              if (slot_cnt == 5'd31) begin
                shift_q <= pop_word;
              end else begin
                shift_q <= {shift_q[30:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Saturating count of frames that started with nothing to send; a clear takes priority
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      uf_count <= '0;
    end else if (clear_underflow) begin
      uf_count <= '0;
    end else if (underflow && (uf_count != 16'hFFFF)) begin
      uf_count <= uf_count + 16'd1;
    end
  end

  assign sample_ready  = ready_q;
  assign fifo_level    = level_q;
  assign underflow_cnt = uf_count;
  assign i2s_bclk      = bclk_q;
  assign i2s_lrclk     = lrclk_q;
  assign i2s_sdata     = sdata_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
`timescale 1ns/1ps
// Directed bench for audio_i2s_tx: reset, single frame, FIFO full and drain,
// underflow saturation and clear priority, mid-frame disable and reset.
module tb_audio_i2s_tx;

  localparam int FIFO_DEPTH = 16;
  localparam int BCLK_DIV   = 2;

  logic        ACLK;
  logic        ARESETN;
  logic        enable;
  logic [31:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [4:0]  fifo_level;
  logic        clear_underflow;
  logic [15:0] underflow_cnt;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;

  int check_count;
  int error_count;

  audio_i2s_tx #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .BCLK_DIV  (BCLK_DIV)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .enable         (enable),
    .sample_data    (sample_data),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .fifo_level     (fifo_level),
    .clear_underflow(clear_underflow),
    .underflow_cnt  (underflow_cnt),
    .i2s_bclk       (i2s_bclk),
    .i2s_lrclk      (i2s_lrclk),
    .i2s_sdata      (i2s_sdata)
  );

  // 100 MHz system clock
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Hard stop in case something stalls beyond every local bound
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Single push, valid held for exactly one edge
  task automatic apply_stimulus(input logic [31:0] word);
    @(negedge ACLK);
    sample_data  = word;
    sample_valid = 1'b1;
    @(negedge ACLK);
    sample_valid = 1'b0;
  endtask

  // Returns at the first falling ACLK edge after bclk has gone high
  task automatic wait_bclk_rise();
    logic prev;
    logic seen;
    prev = i2s_bclk;
    seen = 1'b0;
    for (int i = 0; i < 4 * BCLK_DIV + 4; i++) begin
      @(negedge ACLK);
      if (i2s_bclk && !prev) begin
        seen = 1'b1;
        break;
      end
      prev = i2s_bclk;
    end
    if (!seen) check_output("bclk_rise_timeout", 32'd0, 32'd1);
  endtask

  // Collects slots 1..31 and the next slot 0, MSB first, checking word select per slot
  task automatic receive_word(input string tag, output logic [31:0] word, output logic [15:0] uf_at_31);
    int lr_errs;
    logic lr_exp;
    word     = '0;
    uf_at_31 = '0;
    lr_errs  = 0;
    for (int s = 1; s <= 32; s++) begin
      wait_bclk_rise();
      word   = {word[30:0], i2s_sdata};
      lr_exp = (s >= 16) && (s <= 31);
      if (i2s_lrclk !== lr_exp) lr_errs++;
      if (s == 31) uf_at_31 = underflow_cnt;
    end
    check_output({tag, "_lrclk_errs"}, 32'(lr_errs), 32'd0);
  endtask

  initial begin
    logic [31:0] word;
    logic [15:0] uf;
    int          toggles;
    logic        prev_bclk;

    check_count     = 0;
    error_count     = 0;
    ARESETN         = 1'b0;
    enable          = 1'b0;
    sample_data     = '0;
    sample_valid    = 1'b0;
    clear_underflow = 1'b0;

    // Reset state
    #200;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check_output("rst_ready", 32'(sample_ready), 32'd1);
    check_output("rst_level", 32'(fifo_level), 32'd0);
    check_output("rst_uf", 32'(underflow_cnt), 32'd0);
    check_output("rst_outs", {29'd0, i2s_bclk, i2s_lrclk, i2s_sdata}, 32'd0);
    toggles   = 0;
    prev_bclk = i2s_bclk;
    for (int i = 0; i < 1000; i++) begin
      @(negedge ACLK);
      if (i2s_bclk !== prev_bclk) toggles++;
      prev_bclk = i2s_bclk;
    end
    check_output("idle_bclk_toggles", 32'(toggles), 32'd0);

    // Single frame
    apply_stimulus(32'hA5A5_3C3C);
    check_output("single_level", 32'(fifo_level), 32'd1);
    @(negedge ACLK);
    enable = 1'b1;
    wait_bclk_rise();
    check_output("first_slot0_sdata", 32'(i2s_sdata), 32'd0);
    receive_word("single", word, uf);
    check_output("single_left", 32'(word[31:16]), 32'h0000_A5A5);
    check_output("single_right", 32'(word[15:0]), 32'h0000_3C3C);
    check_output("single_uf", 32'(uf), 32'd0);
    @(negedge ACLK);
    enable = 1'b0;

    // FIFO full, then drain
    @(negedge ACLK);
    clear_underflow = 1'b1;
    @(negedge ACLK);
    clear_underflow = 1'b0;
    check_output("clear_uf", 32'(underflow_cnt), 32'd0);
    for (int i = 1; i <= 17; i++) begin
      @(negedge ACLK);
      check_output($sformatf("ready_before_push%0d", i), 32'(sample_ready), (i <= 16) ? 32'd1 : 32'd0);
      sample_data  = 32'(i);
      sample_valid = 1'b1;
    end
    @(negedge ACLK);
    sample_valid = 1'b0;
    check_output("full_level", 32'(fifo_level), 32'd16);
    check_output("full_ready", 32'(sample_ready), 32'd0);
    @(negedge ACLK);
    enable = 1'b1;
    wait_bclk_rise();
    for (int k = 1; k <= 16; k++) begin
      receive_word($sformatf("drain%0d", k), word, uf);
      check_output($sformatf("drain_word%0d", k), word, 32'(k));
    end
    receive_word("zero_frame", word, uf);
    check_output("zero_frame_word", word, 32'd0);
    check_output("zero_frame_uf", 32'(uf), 32'd1);

    // Underflow saturation
    @(negedge ACLK);
    force dut.uf_count = 16'hFFFD;
    @(negedge ACLK);
    release dut.uf_count;
    receive_word("sat0", word, uf);
    check_output("sat0_uf", 32'(uf), 32'h0000_FFFD);
    receive_word("sat1", word, uf);
    check_output("sat1_uf", 32'(uf), 32'h0000_FFFE);
    receive_word("sat2", word, uf);
    check_output("sat2_uf", 32'(uf), 32'h0000_FFFF);
    receive_word("sat3", word, uf);
    check_output("sat3_uf", 32'(uf), 32'h0000_FFFF);
    check_output("sat3_word", word, 32'd0);

    // Clear coincident with slot 0 entry of an underflowing frame
    @(negedge ACLK);
    enable = 1'b0;
    @(negedge ACLK);
    enable          = 1'b1;
    clear_underflow = 1'b1;
    @(negedge ACLK);
    clear_underflow = 1'b0;
    check_output("clear_wins", 32'(underflow_cnt), 32'd0);
    @(negedge ACLK);
    enable = 1'b0;

    // Mid-frame disable then re-enable
    apply_stimulus(32'hF0F0_F0F0);
    apply_stimulus(32'h1357_9BDF);
    check_output("mid_level_pre", 32'(fifo_level), 32'd2);
    @(negedge ACLK);
    enable = 1'b1;
    wait_bclk_rise();
    for (int s = 1; s <= 10; s++) wait_bclk_rise();
    check_output("s10_sdata", 32'(i2s_sdata), 32'd1);
    check_output("s10_level", 32'(fifo_level), 32'd1);
    enable = 1'b0;
    @(posedge ACLK);
    #1;
    check_output("disable_outs", {29'd0, i2s_bclk, i2s_lrclk, i2s_sdata}, 32'd0);
    check_output("disable_level", 32'(fifo_level), 32'd1);
    @(negedge ACLK);
    enable = 1'b1;
    wait_bclk_rise();
    check_output("reenable_slot0_sdata", 32'(i2s_sdata), 32'd0);
    receive_word("reenable", word, uf);
    check_output("reenable_word", word, 32'h1357_9BDF);

    // Asynchronous reset mid-frame
    apply_stimulus(32'h0000_1111);
    apply_stimulus(32'h0000_2222);
    check_output("pre_reset_level", 32'(fifo_level), 32'd2);
    check_output("pre_reset_uf", 32'(underflow_cnt), 32'd1);
    repeat (20) @(negedge ACLK);
    #2;
    ARESETN = 1'b0;
    enable  = 1'b0;
    #1;
    check_output("async_rst_outs", {29'd0, i2s_bclk, i2s_lrclk, i2s_sdata}, 32'd0);
    check_output("async_rst_level", 32'(fifo_level), 32'd0);
    check_output("async_rst_ready", 32'(sample_ready), 32'd1);
    check_output("async_rst_uf", 32'(underflow_cnt), 32'd0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    repeat (2) @(negedge ACLK);
    check_output("post_rst_level", 32'(fifo_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/audio_i2s_tx.md
# audio_i2s_tx

Streaming audio transmitter that sits directly downstream of the audio AXI4-Lite register slave. It accepts 32-bit stereo sample words ({left[15:0], right[15:0]}) pushed from the register write path and buffers them in an internal FIFO. It serializes one word per frame onto a standard I2S link (BCLK, LRCLK, SDATA) using a clock divider off ACLK. It also reports FIFO level and a saturating underflow count back to the register file.

## Interface
Parameters:
- FIFO_DEPTH, 16, sample FIFO entries; power of two, at least 2
- BCLK_DIV, 4, ACLK cycles per BCLK half-period; at least 1

Ports:
- ACLK  in  1  system clock; all logic on rising edge
- ARESETN  in  1  asynchronous, active-low reset
- enable  in  1  transmitter run control (from control register)
- sample_data  in  32  {left[15:0], right[15:0]}
- sample_valid  in  1  push request
- sample_ready  out  1  high when FIFO not full
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
- clear_underflow  in  1  single-cycle pulse; zeroes underflow_cnt
- underflow_cnt  out  16  frames sent with no sample available, saturating
- i2s_bclk  out  1  bit clock
- i2s_lrclk  out  1  word select; 0 = left, 1 = right
- i2s_sdata  out  1  serial data, MSB first

## Operation
- Reset values: sample_ready=1, fifo_level=0, underflow_cnt=0, i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0. FIFO is empty, divider and slot counter are 0, shift register is 0.
- FIFO push: a push happens when sample_valid && sample_ready. sample_ready = (fifo_level != FIFO_DEPTH). The FIFO accepts pushes regardless of enable.
- Frame: 32 slots numbered s = 0..31, one BCLK period each. lrclk = 0 for s in 0..15 and 1 for s in 16..31.
- On entry to slot 0:
  - If the FIFO is non-empty, pop word W into the shift register.
  - If the FIFO is empty, load 0 and increment underflow_cnt (saturates at 0xFFFF).
- SDATA mapping (I2S one-bit delay):
  - In slot s = 1..31, sdata = W[32-s].
  - In slot 0 of the following frame, sdata = W[0].
  - So left MSB W[31] is in s=1 and right LSB W[0] is in the next s=0.
  - In the first frame after enable rises, slot 0 sdata = 0.
- Disabled (enable=0):
  - Divider and slot counter are held at 0.
  - bclk, lrclk and sdata are held at 0.
  - The shift register is cleared, and no pops or underflow increments occur.
- enable falling mid-frame: outputs go to 0 on the next ACLK edge. The partially sent word is discarded, not returned to the FIFO.
- Simultaneous push and pop: both happen; level is unchanged. On an empty FIFO, the pop sees empty, so the frame underflows and the pushed word remains.
- If clear_underflow and an underflow increment occur in the same cycle, clear wins (count = 0).

## Timing
- Divider counts 0..BCLK_DIV-1 and toggles bclk at the terminal count. BCLK period is 2*BCLK_DIV ACLK cycles.
- Frame length is 64*BCLK_DIV ACLK cycles (256 at default).
- The first ACLK edge with enable=1 enters slot 0 and performs the pop. bclk stays low for BCLK_DIV cycles, then high for BCLK_DIV cycles.
- lrclk and sdata change only on the ACLK edge where bclk falls, and on the enable edge that enters slot 0. They are stable across every bclk rising edge.
- The slot counter advances on each bclk falling edge and wraps from 31 to 0; the wrap is a new frame and a new pop.
- fifo_level and sample_ready are registered and reflect a push or pop on the following cycle. There is no combinational path from sample_valid to sample_ready.
- underflow_cnt updates one cycle after slot 0 entry.
- ARESETN assertion at any time forces all reset values immediately (asynchronously). After ARESETN deasserts, operation resumes at the first enabled edge.

## Test plan
- Reset state: hold ARESETN low for 200 ns, then release with enable=0. Required: all outputs at reset values, sample_ready=1, and no bclk toggles for 1000 cycles.
- Single frame: push 0xA5A5_3C3C, then set enable=1.
  - Sampled on bclk rising edges, sdata for s=1..16 must be 1010010110100101 with lrclk=0 for s=1..15 and lrclk=1 at s=16.
  - For s=17..31 plus the next s=0, sdata must be 0011110000111100.
  - underflow_cnt must stay 0.
- FIFO full: with enable=0, push 17 words 0x1..0x11. Required: sample_ready drops after the 16th push, the 17th push is not accepted, and fifo_level=16.
  - After enable=1, the transmitted words are 0x1..0x10 in order, then an all-zero frame, and underflow_cnt=1.
- Underflow saturation: enable with an empty FIFO and force underflow_cnt near 0xFFFF (or run 65536 frames with BCLK_DIV=1). Required: the count stops at 0xFFFF.
  - A clear_underflow pulse coincident with slot 0 entry leaves the count at 0.
- Mid-frame disable and reset:
  - Drop enable at s=10. Required: bclk, lrclk and sdata are 0 on the next edge, and fifo_level is unchanged.
  - Re-enable. Required: the next FIFO word is sent in full.
  - Assert ARESETN mid-frame. Required: immediate return to reset values and the FIFO is emptied.
